// File: rtl/matrix_operand_loader.sv
// Byte-stream loader that fills two 4x4 operand matrices and launches matrix_addition.
// Optional WAIT watchdog is compiled in with `define MATRIX_LOADER_TIMEOUT_EN.
//
// state  | meaning
// LOAD_A | accepting bytes into a_out, row-major
// LOAD_B | accepting bytes into b_out, row-major
// START  | holding start high for START_CYCLES cycles
// WAIT   | operands stable, waiting for the adder's done
module matrix_operand_loader #(
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [0:3][0:3][7:0]   a_out,
   output logic [0:3][0:3][7:0]   b_out,
   output logic                   start,
   input  logic                   done,
   output logic                   busy,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, START, WAIT} state_t;

   localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

   state_t     state;
   logic [3:0] idx;
   logic [3:0] start_cnt;
   logic       done_seen;
   logic       xfer;

`ifdef MATRIX_LOADER_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_cnt;
`endif

   assign xfer = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD_A;
         idx       <= 4'd0;
         start_cnt <= 4'd0;
         done_seen <= 1'b0;
         in_ready  <= 1'b0;
         start     <= 1'b0;
         busy      <= 1'b0;
         a_out     <= '0;
         b_out     <= '0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
         wd_cnt      <= 16'd0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD_A: begin
               in_ready  <= 1'b1;
               done_seen <= 1'b0;
               if (xfer) begin
                  a_out[idx[3:2]][idx[1:0]] <= in_data;
                  idx <= idx + 4'd1;
                  if (idx == 4'd15)
                     state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  b_out[idx[3:2]][idx[1:0]] <= in_data;
                  idx <= idx + 4'd1;
                  if (idx == 4'd15) begin
                     state     <= START;
                     in_ready  <= 1'b0;
                     start     <= 1'b1;
                     busy      <= 1'b1;
                     start_cnt <= 4'd0;
                  end
               end
            end
            START: begin
               start_cnt <= start_cnt + 4'd1;
               if (done)
                  done_seen <= 1'b1;
               if (start_cnt == START_LAST) begin
                  start <= 1'b0;
                  // A fast adder may already have finished inside the start window.
                  if (done_seen) begin
                     state     <= LOAD_A;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                     done_seen <= 1'b0;
                  end else begin
                     state <= WAIT;
`ifdef MATRIX_LOADER_TIMEOUT_EN
                     wd_cnt <= 16'd0;
`endif
                  end
               end
            end
            WAIT: begin
               if (done || done_seen) begin
                  state     <= LOAD_A;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  done_seen <= 1'b0;
               end
`ifdef MATRIX_LOADER_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= LOAD_A;
                  in_ready    <= 1'b1;
                  busy        <= 1'b0;
                  done_seen   <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
`endif
            end
            default: begin
               state    <= LOAD_A;
               in_ready <= 1'b0;
               start    <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

`ifndef MATRIX_LOADER_TIMEOUT_EN
   // No watchdog in this build; the parameter only keeps the interface uniform.
   assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: random byte sets, gaps, early/late done, reset mid-load.
module tb_matrix_operand_loader;

   localparam int SC = 2;

   typedef struct {
      logic [0:3][0:3][7:0] a;
      logic [0:3][0:3][7:0] b;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [7:0]           in_data = 8'd0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [0:3][0:3][7:0] a_out;
   logic [0:3][0:3][7:0] b_out;
   logic                 start;
   logic                 done = 1'b0;
   logic                 busy;
   logic                 timeout_err;

   matrix_operand_loader #(.START_CYCLES(SC), .TIMEOUT_CYCLES(2500)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .a_out(a_out), .b_out(b_out), .start(start),
      .done(done), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [7:0] cur[$];
   exp_t       exp_q[$];
   exp_t       sum_q[$];
   int         mode_q[$];
   int         next_mode = 3;
   int         set0_cyc = 0;
   int         rise_cyc = 0;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference model: every 32 accepted bytes form one operand set, A first then B, row-major.
   task automatic commit(input logic [7:0] b);
      exp_t e;
      if (cur.size() == 0) set0_cyc = cyc;
      cur.push_back(b);
      if (cur.size() == 32) begin
         for (int k = 0; k < 16; k++) begin
            e.a[k / 4][k % 4] = cur[k];
            e.b[k / 4][k % 4] = cur[16 + k];
         end
         exp_q.push_back(e);
         sum_q.push_back(e);
         mode_q.push_back(next_mode);
         cur.delete();
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk(in_ready, "accept_timeout", {127'd0, in_ready}, 128'd1);
         in_valid = 1'b0;
         return;
      end
      commit(b);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || mode_q.size() != 0 || busy || !in_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(n < 400, "idle_timeout", 128'(n), 128'd400);
   endtask

   // Monitor: pops the expected set on each start rise and checks the start pulse width.
   initial begin
      bit   prev;
      int   len;
      exp_t e;
      prev = 1'b0;
      len  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
            len  = 0;
         end else begin
            if (busy) chk(!in_ready, "ready_low_when_busy", {127'd0, in_ready}, 128'd0);
            if (start && !prev) begin
               rise_cyc = cyc;
               if (exp_q.size() == 0) begin
                  chk(exp_q.size() != 0, "unexpected_start", 128'd1, 128'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk(a_out == e.a, "a_out", a_out, e.a);
                  chk(b_out == e.b, "b_out", b_out, e.b);
               end
            end
            if (start) len++;
            else if (prev) begin
               chk(len == SC, "start_len", 128'(len), 128'(SC));
               len = 0;
            end
            prev = start;
         end
      end
   end

   // Adder stand-in: answers each launch early (mode 0) or after mode cycles, checking c = a + b.
   initial begin
      bit   rprev;
      int   m;
      int   nerr;
      exp_t e;
      rprev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && start && !rprev) begin
            m = 3;
            if (mode_q.size() == 0) chk(mode_q.size() != 0, "mode_missing", 128'd0, 128'd1);
            else m = mode_q.pop_front();
            if (m != 0) begin
               repeat (m) @(negedge clk);
               chk(busy && !in_ready, "wait_state", {126'd0, busy, in_ready}, 128'h2);
            end
            nerr = 0;
            if (sum_q.size() != 0) begin
               e = sum_q.pop_front();
               for (int i = 0; i < 4; i++)
                  for (int j = 0; j < 4; j++)
                     if (9'(a_out[i][j]) + 9'(b_out[i][j]) != 9'(e.a[i][j]) + 9'(e.b[i][j])) nerr++;
            end else nerr = 99;
            chk(nerr == 0, "adder_c", 128'(nerr), 128'd0);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            if (m == 0) @(negedge clk);
            chk(in_ready && !busy, m == 0 ? "early_done_return" : "done_return",
                {126'd0, in_ready, busy}, 128'h2);
         end
         rprev = start;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk(in_ready == 1'b0, "rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk(start == 1'b0, "rst_start", {127'd0, start}, 128'd0);
      chk(busy == 1'b0, "rst_busy", {127'd0, busy}, 128'd0);
      chk(timeout_err == 1'b0, "rst_timeout_err", {127'd0, timeout_err}, 128'd0);
      chk(a_out == '0, "rst_a_out", a_out, 128'd0);
      chk(b_out == '0, "rst_b_out", b_out, 128'd0);
      rst_n = 1'b1;
      chk(in_ready == 1'b0, "ready_at_release", {127'd0, in_ready}, 128'd0);
      @(negedge clk);
      chk(in_ready == 1'b1, "ready_after_release", {127'd0, in_ready}, 128'd1);

      // Single load of bytes 0..31 back-to-back.
      next_mode = 3;
      for (int k = 0; k < 32; k++) send(8'(k), 0);
      wait_idle();
      chk(rise_cyc - set0_cyc == 32, "throughput", 128'(rise_cyc - set0_cyc), 128'd32);

      // Early done inside the start window.
      next_mode = 0;
      for (int k = 0; k < 32; k++) send(8'($urandom_range(0, 255)), 0);
      wait_idle();

      // Gapped set, then a set whose first byte is offered during WAIT.
      next_mode = 4;
      for (int k = 0; k < 32; k++) send(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      next_mode = 2;
      for (int k = 0; k < 32; k++) send(8'($urandom_range(0, 255)), 0);
      wait_idle();

      // Reset after 20 bytes discards the partial set.
      next_mode = 3;
      for (int k = 0; k < 20; k++) send(8'($urandom_range(0, 255)), 0);
      rst_n = 1'b0;
      cur.delete();
      #1;
      chk(a_out == '0, "midrst_a_out", a_out, 128'd0);
      chk(b_out == '0, "midrst_b_out", b_out, 128'd0);
      chk(in_ready == 1'b0, "midrst_in_ready", {127'd0, in_ready}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 32; k++) send(8'($urandom_range(0, 255)), 0);
      wait_idle();

      // Random sets with random gaps and done timing.
      for (int s = 0; s < 100; s++) begin
         next_mode = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 6));
         for (int k = 0; k < 32; k++)
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      wait_idle();
      chk(timeout_err == 1'b0, "timeout_err_default", {127'd0, timeout_err}, 128'd0);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for `matrix_addition`. It accepts a byte stream over a valid/ready handshake and assembles two 4×4 8-bit operand matrices, `a_out` then `b_out`. It then drives `start` to the adder and waits for the adder's `done` before accepting the next operand set. Registered outputs connect directly to the adder's `a`, `b`, `start` and `done` ports.

## Interface
- `START_CYCLES`, default 2: cycles `start` is held high per launch (1..15).
- `TIMEOUT_CYCLES`, default 2500: watchdog limit in WAIT (used only with the macro).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_data` input, 8 bits: operand byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the loader accepts a byte this cycle.
- `a_out` output, [0:3][0:3]×8 bits: matrix A to the adder.
- `b_out` output, [0:3][0:3]×8 bits: matrix B to the adder.
- `start` output, 1 bit: launch pulse to the adder.
- `done` input, 1 bit: completion from the adder.
- `busy` output, 1 bit: high in START or WAIT.
- `timeout_err` output, 1 bit: sticky watchdog flag (compiled as constant 0 without the macro).

## Operation
- States: LOAD_A, LOAD_B, START, WAIT. Reset state is LOAD_A.
- 4-bit element index `idx`: row = `idx[3:2]`, col = `idx[1:0]`, row-major order.
- Transfer occurs when `in_valid && in_ready`.
- LOAD_A:
  - `in_ready`=1.
  - Each transfer writes `a_out[row][col]` and increments `idx`.
  - The transfer at `idx`=15 wraps `idx` to 0 and moves to LOAD_B.
- LOAD_B: same behaviour writing `b_out`. The transfer at `idx`=15 moves to START and clears `start_cnt`.
- START:
  - `start`=1, `in_ready`=0.
  - `start_cnt` increments each cycle.
  - After `START_CYCLES` cycles, go to WAIT, or to LOAD_A if `done_seen` is set.
- WAIT:
  - `start`=0, `in_ready`=0.
  - On `done`=1 or `done_seen`=1, go to LOAD_A.
- `done_seen`:
  - Set by `done`=1 in any START cycle.
  - Cleared on entry to LOAD_A.
  - Covers a fast adder that finishes inside the start window.
- `done` is ignored in LOAD_A and LOAD_B.
- `a_out` and `b_out` hold their values from the last write until overwritten. Nothing clears them except reset.
- While loading the next set, `a_out` is partially updated. The adder must not be relied on outside START/WAIT.
- `in_data` is ignored when `in_ready`=0. No byte is lost or duplicated: a byte offered while `in_ready`=0 stays pending at the source.
- Reset mid-operation, whether mid-load or mid-WAIT:
  - State returns to LOAD_A, `idx`=0, all matrices zero.
  - A partial set is discarded.

## Timing
- Reset values:
  - Outputs: `in_ready`=0 while `rst_n`=0, `start`=0, `busy`=0, `timeout_err`=0, `a_out`=0, `b_out`=0.
  - Internal: `idx`=0, `start_cnt`=0, `done_seen`=0.
- `in_ready` goes high on the first cycle after `rst_n` deasserts.
- Throughput: one byte per cycle with `in_valid` held high. 32 bytes take 32 cycles.
- Launch timing:
  - The 32nd transfer is accepted in cycle N.
  - Operands are complete and `start`=1 from cycle N+1 through N+`START_CYCLES`.
  - `busy`=1 from N+1.
- `done` seen in WAIT at cycle M gives `in_ready`=1 and `busy`=0 at cycle M+1.
- All outputs are registered. No combinational path from `in_valid` or `done` to any output.

## Configuration
- Macro `MATRIX_LOADER_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counts WAIT cycles and clears on WAIT entry.
  - When the count reaches `TIMEOUT_CYCLES` without `done`, `timeout_err` is set and the state returns to LOAD_A.
  - `timeout_err` clears only on reset.
- Undefined:
  - No counter is built; WAIT lasts until `done`.
  - `timeout_err` is tied to 0.

## Test plan
- **Single load:** reset, then stream bytes 0..31 back-to-back.
  - `a_out[i][j]` = 4i+j and `b_out[i][j]` = 16+4i+j.
  - `start` high exactly 2 cycles, starting the cycle after byte 31.
  - `in_ready`=0 until `done`.
- **Backpressure and gaps:** randomly gap `in_valid`, and offer a byte during WAIT.
  - The WAIT byte is not consumed; it is accepted as A[0][0] after `done`.
  - Matrices match the bytes sent.
- **Early done:** `done` pulses in the first START cycle.
  - The loader returns to LOAD_A after the 2 START cycles, with no hang in WAIT.
- **Reset mid-load:** assert `rst_n`=0 after 20 bytes.
  - All matrices are 0 and `idx`=0.
  - The next 32 bytes form a complete new set.
- **Integrated with `matrix_addition`:** run 100 random sets; adder `c[i][j]` equals `a_out[i][j]`+`b_out[i][j]` (range 0..510) each round.
- **Timeout (`MATRIX_LOADER_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=10):** `done` is never asserted.
  - `timeout_err`=1 after 10 WAIT cycles and `in_ready`=1 next cycle.
  - The flag is still set after the next load.
